// File: rtl/ether_pkg.sv
// Shared FSM state type and CRC-32 constants for the ether_bytes RMII byte assembler.
package ether_pkg;

    typedef enum logic [1:0] {IDLE, RECV, FLUSH, BLOCK} state_t;

    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

endpackage

// File: rtl/ether_crc32.sv
// Combinational reflected CRC-32 step consuming one dibit, low bit first.
module ether_crc32
    import ether_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [1:0]  dibit,
    output logic [31:0] crc_out
);

    always_comb begin
        logic [31:0] c;
        c = crc_in;
        for (int unsigned i = 0; i < 2; i++) begin
            if (c[0] ^ dibit[i]) begin
                c = (c >> 1) ^ CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/ether_bytes.sv
// RMII dibit-to-byte assembler with frame delimiting and length/alignment checks.
// Define ETHER_CRC_CHECK_EN to build in the FCS residue checker driving crc_ok.
module ether_bytes
    import ether_pkg::*;
#(
    parameter int unsigned MAX_BYTES = 1522
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       axiiv,
    input  logic [1:0] axiid,
    output logic       axiov,
    output logic [7:0] axiod,
    output logic       sof,
    output logic       eof,
    output logic       frame_err,
    output logic       crc_ok
);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [5:0]  sh_q, sh_d;
    logic [10:0] bytes_q, bytes_d;
    logic        axiov_q, axiov_d;
    logic [7:0]  axiod_q, axiod_d;
    logic        sof_q, sof_d;
    logic        eof_q, eof_d;
    logic        err_q, err_d;
    logic        accept, start;
    logic [1:0]  cur_cnt;
    logic [10:0] cur_bytes;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        bytes_d   = bytes_q;
        axiov_d   = 1'b0;
        axiod_d   = axiod_q;
        sof_d     = 1'b0;
        eof_d     = 1'b0;
        err_d     = 1'b0;
        accept    = 1'b0;
        start     = 1'b0;
        cur_cnt   = cnt_q;
        cur_bytes = bytes_q;

        case (state_q)
            BLOCK: begin
                if (!axiiv) state_d = IDLE;
            end
            IDLE, FLUSH: begin
                // A dibit during FLUSH opens the next frame with no extra idle cycle.
                if (axiiv) begin
                    state_d = RECV;
                    accept  = 1'b1;
                    start   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RECV: begin
                if (axiiv) begin
                    accept = 1'b1;
                end else begin
                    state_d = FLUSH;
                    eof_d   = 1'b1;
                    err_d   = (cnt_q != 2'd0) || (32'(bytes_q) > MAX_BYTES);
                end
            end
            default: state_d = BLOCK;
        endcase

        if (start) begin
            cur_cnt   = 2'd0;
            cur_bytes = '0;
        end

        if (accept) begin
            sh_d    = {axiid, sh_q[5:2]};
            cnt_d   = cur_cnt + 2'd1;
            bytes_d = cur_bytes;
            if (cur_cnt == 2'd3) begin
                axiov_d = 1'b1;
                axiod_d = {axiid, sh_q};
                sof_d   = (cur_bytes == '0);
                bytes_d = (cur_bytes == '1) ? cur_bytes : cur_bytes + 11'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BLOCK;
            cnt_q   <= '0;
            sh_q    <= '0;
            bytes_q <= '0;
            axiov_q <= 1'b0;
            axiod_q <= '0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            bytes_q <= bytes_d;
            axiov_q <= axiov_d;
            axiod_q <= axiod_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
            err_q   <= err_d;
        end
    end

    assign axiov     = axiov_q;
    assign axiod     = axiod_q;
    assign sof       = sof_q;
    assign eof       = eof_q;
    assign frame_err = err_q;

`ifdef ETHER_CRC_CHECK_EN
    logic [31:0] crc_q, crc_d, crc_step_in, crc_step_out;
    logic        crc_ok_q, crc_ok_d;

    assign crc_step_in = start ? CRC_INIT : crc_q;

    ether_crc32 u_crc32 (
        .crc_in  (crc_step_in),
        .dibit   (axiid),
        .crc_out (crc_step_out)
    );

    always_comb begin
        crc_d    = accept ? crc_step_out : crc_q;
        crc_ok_d = eof_d && (crc_q == CRC_RESIDUE) && !err_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc_q    <= '0;
            crc_ok_q <= 1'b0;
        end else begin
            crc_q    <= crc_d;
            crc_ok_q <= crc_ok_d;
        end
    end

    assign crc_ok = crc_ok_q;
`else
    assign crc_ok = 1'b0;
`endif

endmodule
